conv_engine: RTL and testbench

//  Sequential convolution core: z[i] = sum_k x[k]*y[i-k], i = 0..size_x+size_y-2.

---
 rtl/conv_engine.sv | 201 ++++++++++++++++++++
 tb/tb_conv_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine.sv
// ---------------------------------------------------------------------------
// conv_engine
// Sequential convolution core: z[i] = sum_k x[k]*y[i-k], i = 0..sx+sy-2.
// Operands are read from the X/Y sample memories (1-cycle read latency).
// Each saturated result word is written to the Z memory over its write port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job request, sampled only while idle
//   size_x, size_y    operand lengths, latched when start is accepted
//   x_addr/x_rd/x_data  X memory read port (data valid the cycle after x_rd)
//   y_addr/y_rd/y_data  Y memory read port (data valid the cycle after y_rd)
//   z_addr/z_we/z_data  Z memory write port, one z_we pulse per result
//   busy              high whenever the engine is not idle
//   done              single-cycle pulse at the end of a job
//
// Handshake: start is a level sampled in IDLE only. Once accepted, busy stays
// high until the cycle after the done pulse. start seen while busy is dropped.
// Reset abandons any job without a done pulse.
// ---------------------------------------------------------------------------
module conv_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] size_x,
  input  logic [ADDR_WIDTH-1:0] size_y,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic                  x_rd,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic [ADDR_WIDTH-1:0] y_addr,
  output logic                  y_rd,
  input  logic [DATA_WIDTH-1:0] y_data,
  output logic [ADDR_WIDTH:0]   z_addr,
  output logic                  z_we,
  output logic [DATA_WIDTH-1:0] z_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW    = ADDR_WIDTH;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = 2 * DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FETCH = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q;
  logic [AW-1:0]      sx_q, sy_q;
  logic [AW1-1:0]     i_q;
  logic [AW-1:0]      k_q, k_hi_q;
  logic [ACC_W-1:0]   acc_q;
  logic [AW-1:0]      x_addr_q, y_addr_q;
  logic               x_rd_q, y_rd_q;
  logic [AW1-1:0]     z_addr_q;
  logic               z_we_q;
  logic [DW-1:0]      z_data_q;
  logic               busy_q, done_q;

  // Combinational helpers feeding the FSM
  logic [AW1-1:0]     i_plus1_d;
  logic [AW-1:0]      k_lo_d, k_hi_d, sx_m1_d, y_lo_d, k_nx_d, y_nx_d;
  logic [AW1-1:0]     i_last_d;
  logic [PW-1:0]      prod_d;
  logic [ACC_W-1:0]   acc_d;

  function automatic logic [DW-1:0] sat(input logic [ACC_W-1:0] a);
    if (|a[ACC_W-1:DW]) sat = '1;
    else                sat = a[DW-1:0];
  endfunction

  always_comb begin
    i_plus1_d = i_q + AW1'(1);
    // First term index: max(0, i - sy + 1)
    if (i_plus1_d > {1'b0, sy_q}) k_lo_d = AW'(i_plus1_d - {1'b0, sy_q});
    else                          k_lo_d = '0;
    // Last term index: min(i, sx - 1)
    sx_m1_d  = sx_q - AW'(1);
    k_hi_d   = (i_q < {1'b0, sx_m1_d}) ? i_q[AW-1:0] : sx_m1_d;
    // i - k always lies in 0..sy-1 for valid k, so truncation is safe
    y_lo_d   = AW'(i_q - {1'b0, k_lo_d});
    k_nx_d   = k_q + AW'(1);
    y_nx_d   = AW'(i_q - {1'b0, k_nx_d});
    i_last_d = {1'b0, sx_q} + {1'b0, sy_q} - AW1'(2);
    prod_d   = PW'(x_data) * PW'(y_data);
    acc_d    = acc_q + ACC_W'(prod_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sx_q     <= '0;
      sy_q     <= '0;
      i_q      <= '0;
      k_q      <= '0;
      k_hi_q   <= '0;
      acc_q    <= '0;
      x_addr_q <= '0;
      y_addr_q <= '0;
      x_rd_q   <= 1'b0;
      y_rd_q   <= 1'b0;
      z_addr_q <= '0;
      z_we_q   <= 1'b0;
      z_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sx_q   <= size_x;
            sy_q   <= size_y;
            busy_q <= 1'b1;
            if (size_x == '0 || size_y == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              i_q     <= '0;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          // Read strobes are registered, so the first fetch is issued here
          acc_q    <= '0;
          k_q      <= k_lo_d;
          k_hi_q   <= k_hi_d;
          x_rd_q   <= 1'b1;
          y_rd_q   <= 1'b1;
          x_addr_q <= k_lo_d;
          y_addr_q <= y_lo_d;
          state_q  <= S_FETCH;
        end
        S_FETCH: begin
          x_rd_q  <= 1'b0;
          y_rd_q  <= 1'b0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (k_q < k_hi_q) begin
            k_q      <= k_nx_d;
            x_rd_q   <= 1'b1;
            y_rd_q   <= 1'b1;
            x_addr_q <= k_nx_d;
            y_addr_q <= y_nx_d;
            state_q  <= S_FETCH;
          end else begin
            // Final accumulate feeds the write port directly
            z_we_q   <= 1'b1;
            z_addr_q <= i_q;
            z_data_q <= sat(acc_d);
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          z_we_q   <= 1'b0;
          z_data_q <= '0;
          if (i_q < i_last_d) begin
            i_q     <= i_plus1_d;
            state_q <= S_SETUP;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_addr = x_addr_q;
  assign x_rd   = x_rd_q;
  assign y_addr = y_addr_q;
  assign y_rd   = y_rd_q;
  assign z_addr = z_addr_q;
  assign z_we   = z_we_q;
  assign z_data = z_data_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_conv_engine.sv
// ---------------------------------------------------------------------------
// tb_conv_engine
// Bench for conv_engine: behavioural memory models for X/Y, a reference
// convolution computed with plain loops into an expected queue, and a
// negedge monitor that scores every Z write, busy cycle and done pulse.
// ---------------------------------------------------------------------------
module tb_conv_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  size_x, size_y;
  logic [4:0]  x_addr, y_addr;
  logic        x_rd, y_rd;
  logic [7:0]  x_data, y_data;
  logic [5:0]  z_addr;
  logic        z_we;
  logic [7:0]  z_data;
  logic        busy, done;

  conv_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .size_x (size_x),
    .size_y (size_y),
    .x_addr (x_addr),
    .x_rd   (x_rd),
    .x_data (x_data),
    .y_addr (y_addr),
    .y_rd   (y_rd),
    .y_data (y_data),
    .z_addr (z_addr),
    .z_we   (z_we),
    .z_data (z_data),
    .busy   (busy),
    .done   (done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- operand memories ----------------
  logic [7:0] xm [32];
  logic [7:0] ym [32];

  always @(posedge clk) begin
    if (x_rd) x_data <= xm[x_addr];
    if (y_rd) y_data <= ym[y_addr];
  end

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int last_waddr = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (z_we) begin
        wr_cnt++;
        last_waddr = int'(z_addr);
        if (exp_q.size() == 0) check("z_unexpected", 32'd1, 32'd0);
        else check("z_write", {18'd0, z_addr, z_data}, {18'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- reference model ----------------
  // Direct evaluation of the convolution sum; also yields the expected
  // job length from the number of terms contributing to each output.
  task automatic model(input int sx, input int sy, output int cyc, output int nw);
    cyc = 0;
    nw  = 0;
    if (sx == 0 || sy == 0) return;
    for (int i = 0; i <= sx + sy - 2; i++) begin
      int s;
      int t;
      logic [7:0] zv;
      logic [5:0] za;
      s = 0;
      t = 0;
      for (int k = 0; k < sx; k++) begin
        if (i - k >= 0 && i - k < sy) begin
          s += int'(xm[k]) * int'(ym[i - k]);
          t++;
        end
      end
      zv = (s > 255) ? 8'd255 : s[7:0];
      za = i[5:0];
      exp_q.push_back({za, zv});
      cyc += 2 * t + 2;
      nw++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_rand(input int maxv);
    for (int a = 0; a < 32; a++) begin
      xm[a] = 8'($urandom_range(0, maxv));
      ym[a] = 8'($urandom_range(0, maxv));
    end
  endtask

  // Runs one job; poke_at >= 0 pulses start with other sizes mid-job.
  task automatic run_job(input int sx, input int sy, input int poke_at);
    int exp_cyc, exp_wr, cyc, b0, d0, w0;
    model(sx, sy, exp_cyc, exp_wr);
    b0 = busy_cnt;
    d0 = done_cnt;
    w0 = wr_cnt;
    size_x = 5'(sx);
    size_y = 5'(sy);
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      if (cyc == poke_at) begin
        start  = 1'b1;
        size_x = 5'(sx + 3);
        size_y = 5'(sy + 5);
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("job_cycles", 32'(cyc), 32'(exp_cyc));
    tick();
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_cycles", 32'(busy_cnt - b0), 32'(exp_cyc + 1));
    check("write_count", 32'(wr_cnt - w0), 32'(exp_wr));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited, d0, w0;
    rst_n  = 1'b0;
    start  = 1'b0;
    size_x = '0;
    size_y = '0;
    fill_rand(255);
    tick();
    tick();
    check("reset_outputs",
          {3'd0, x_addr, x_rd, y_addr, y_rd, z_addr, z_we, z_data, busy, done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic: x=[1,2,3], y=[1,1] -> (0,1) (1,3) (2,5) (3,3), 20 cycles
    xm[0] = 8'd1; xm[1] = 8'd2; xm[2] = 8'd3;
    ym[0] = 8'd1; ym[1] = 8'd1;
    run_job(3, 2, -1);

    // Saturation on every output
    xm[0] = 8'd255; xm[1] = 8'd255;
    ym[0] = 8'd255; ym[1] = 8'd255;
    run_job(2, 2, -1);

    // Exactly at the saturation limit, then one past it
    xm[0] = 8'd15; ym[0] = 8'd17;
    run_job(1, 1, -1);
    xm[0] = 8'd16; ym[0] = 8'd16;
    run_job(1, 1, -1);

    // Zero sizes: no writes, one busy cycle, one done
    run_job(0, 4, -1);
    run_job(5, 0, -1);

    // Start while busy with different sizes
    fill_rand(40);
    run_job(3, 2, 4);
    fill_rand(255);
    run_job(4, 3, 9);

    // Reset during MAC
    fill_rand(60);
    begin
      int c, n;
      model(4, 4, c, n);
    end
    size_x = 5'd4;
    size_y = 5'd4;
    start  = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (!x_rd && waited < 100) begin
      tick();
      waited++;
    end
    check("fetch_seen", 32'(waited < 100), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_midjob_outputs",
          {3'd0, x_addr, x_rd, y_addr, y_rd, z_addr, z_we, z_data, busy, done}, 32'd0);
    exp_q.delete();
    d0 = done_cnt;
    w0 = wr_cnt;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    check("reset_no_done", 32'(done_cnt - d0), 32'd0);
    check("reset_no_write", 32'(wr_cnt - w0), 32'd0);
    check("reset_idle", {31'd0, busy}, 32'd0);
    run_job(4, 4, -1);

    // Max size, all ones: z[i] = terms(i), 61 writes ending at address 60
    for (int a = 0; a < 32; a++) begin
      xm[a] = 8'd1;
      ym[a] = 8'd1;
    end
    run_job(31, 31, -1);
    check("last_zaddr", 32'(last_waddr), 32'd60);

    // Randomized jobs
    for (int r = 0; r < 10; r++) begin
      fill_rand((r % 2 == 0) ? 30 : 255);
      run_job(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
